// File: rtl/din_debounce_pkg.sv
// Shared types and default parameters for the input debounce/synchroniser block.
package din_debounce_pkg;

  // Two-state debounce controller: idle on a stable level, or counting a run.
  typedef enum logic [0:0] {
    ST_STABLE = 1'b0,
    ST_WAIT   = 1'b1
  } db_state_t;

  // Default synchroniser depth.
  localparam int DB_SYNC_STAGES_DEF = 2;
  // Default number of consecutive differing samples needed to accept a new level.
  localparam int DB_CYCLES_DEF      = 4;

endpackage : din_debounce_pkg

// File: rtl/sig_sync_chain.sv
// N-flop shift-register synchroniser for a single asynchronous bit.
// Reset loads every stage with RESET_LEVEL so the chain output starts
// from a known level.
module sig_sync_chain #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the chain every cycle; reset is synchronous, active-low.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every stage samples the
    // value of its neighbour from before the edge; blocking would collapse the chain.
    if (!rst) begin
      chain <= {STAGES{RESET_LEVEL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule : sig_sync_chain

// File: rtl/din_debounce_sync.sv
// Input-conditioning stage: synchronises an asynchronous level into clk,
// rejects runs shorter than DEBOUNCE_CYCLES samples, and emits the clean
// level with one-cycle rise/fall pulses. The clean level feeds downstream D inputs.
module din_debounce_sync
  import din_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = DB_SYNC_STAGES_DEF,
  parameter int   DEBOUNCE_CYCLES = DB_CYCLES_DEF,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sig_in,
  output logic q_clean,
  output logic rise,
  output logic fall,
  output logic busy
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; sized so that value always fits.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject illegal parameterisations at elaboration time.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("din_debounce_sync: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
    $error("din_debounce_sync: DEBOUNCE_CYCLES must be >= 1");
  end

  logic             s;
  logic [CNT_W-1:0] cnt;
  db_state_t        state;

  sig_sync_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sig_in),
    .q   (s)
  );

  // Run-length counter, debounce FSM and registered outputs, all in one clocked process.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_STABLE;
      cnt     <= '0;
      q_clean <= RESET_LEVEL;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      // Pulses are single-cycle: default low, raised only on the flipping edge.
      rise <= 1'b0;
      fall <= 1'b0;
      if (!en) begin
        // Disabled: freeze the output and drop any partially counted run.
        state <= ST_STABLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          ST_STABLE: begin
            if (s != q_clean) begin
              if (DEBOUNCE_CYCLES == 1) begin
                q_clean <= s;
                rise    <= s;
                fall    <= ~s;
                cnt     <= '0;
              end else begin
                cnt   <= CNT_ONE;
                state <= ST_WAIT;
              end
            end else begin
              cnt <= '0;
            end
          end
          ST_WAIT: begin
            if (s == q_clean) begin
              // Level went back before the run completed: treat as a glitch.
              cnt   <= '0;
              state <= ST_STABLE;
            end else if (cnt == CNT_LAST) begin
              q_clean <= ~q_clean;
              rise    <= ~q_clean;
              fall    <= q_clean;
              cnt     <= '0;
              state   <= ST_STABLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            cnt   <= '0;
            state <= ST_STABLE;
          end
        endcase
      end
    end
  end

  assign busy = (state == ST_WAIT);

endmodule : din_debounce_sync

// File: tb/tb_din_debounce_sync.sv
// Directed bench for din_debounce_sync: default instance (2 sync stages,
// 4-sample debounce) plus a DEBOUNCE_CYCLES=1 instance for the short-latency case.
module tb_din_debounce_sync;

  logic clk = 1'b0;
  logic rst, en, sig_in;
  logic q_clean, rise, fall, busy;
  logic rst1, sig_in1;
  logic q_clean1, rise1, fall1, busy1;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  din_debounce_sync dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sig_in  (sig_in),
    .q_clean (q_clean),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy)
  );

  din_debounce_sync #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk     (clk),
    .rst     (rst1),
    .en      (en),
    .sig_in  (sig_in1),
    .q_clean (q_clean1),
    .rise    (rise1),
    .fall    (fall1),
    .busy    (busy1)
  );

  // Advance one active edge, then settle 1 time unit so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; sig_in = 1'b1;
    rst1 = 1'b0; sig_in1 = 1'b0;

    // 1: reset with sig_in=1, then the level propagates and rises at edge 6
    tick();
    check("rst_q", q_clean, 1'b0);
    check("rst_rise", rise, 1'b0);
    check("rst_fall", fall, 1'b0);
    check("rst_busy", busy, 1'b0);
    tick();
    check("rst_q_2", q_clean, 1'b0);
    check("rst_busy_2", busy, 1'b0);
    rst = 1'b1;
    repeat (5) tick();
    check("post_rst_q_e5", q_clean, 1'b0);
    tick();
    check("post_rst_q_e6", q_clean, 1'b1);
    check("post_rst_rise_e6", rise, 1'b1);
    tick();
    check("post_rst_rise_e7", rise, 1'b0);

    // 4: clean fall from q_clean=1
    sig_in = 1'b0;
    tick(); tick();
    check("fall_busy_e2", busy, 1'b0);
    tick();
    check("fall_busy_e3", busy, 1'b1);
    tick(); tick();
    check("fall_busy_e5", busy, 1'b1);
    check("fall_q_e5", q_clean, 1'b1);
    tick();
    check("fall_q_e6", q_clean, 1'b0);
    check("fall_pulse_e6", fall, 1'b1);
    check("fall_norise_e6", rise, 1'b0);
    check("fall_busy_e6", busy, 1'b0);
    tick();
    check("fall_pulse_e7", fall, 1'b0);

    // 3: glitch of 3 samples is rejected
    sig_in = 1'b1;
    repeat (3) tick();
    sig_in = 1'b0;
    for (int e = 4; e <= 10; e++) begin
      tick();
      check($sformatf("glitch_q_e%0d", e), q_clean, 1'b0);
      check($sformatf("glitch_rise_e%0d", e), rise, 1'b0);
      if (e == 5) check("glitch_busy_e5", busy, 1'b1);
    end
    check("glitch_busy_end", busy, 1'b0);

    // 2: clean rise
    sig_in = 1'b1;
    repeat (3) tick();
    check("rise_busy_e3", busy, 1'b1);
    check("rise_q_e3", q_clean, 1'b0);
    tick(); tick();
    check("rise_busy_e5", busy, 1'b1);
    check("rise_q_e5", q_clean, 1'b0);
    check("rise_nopulse_e5", rise, 1'b0);
    tick();
    check("rise_q_e6", q_clean, 1'b1);
    check("rise_pulse_e6", rise, 1'b1);
    check("rise_nofall_e6", fall, 1'b0);
    tick();
    check("rise_pulse_e7", rise, 1'b0);
    check("rise_q_e7", q_clean, 1'b1);

    // 5: en low mid-run clears the count
    sig_in = 1'b0;
    repeat (8) tick();
    check("en_pre_q", q_clean, 1'b0);
    sig_in = 1'b1;
    repeat (4) tick();
    check("en_busy_e4", busy, 1'b1);
    en = 1'b0;
    tick(); tick();
    check("en_off_busy", busy, 1'b0);
    check("en_off_q", q_clean, 1'b0);
    en = 1'b1;
    repeat (3) tick();
    check("en_on_q_e3", q_clean, 1'b0);
    check("en_on_busy_e3", busy, 1'b1);
    tick();
    check("en_on_q_e4", q_clean, 1'b1);
    check("en_on_rise_e4", rise, 1'b1);

    // 6: reset mid-run discards the pending count
    sig_in = 1'b0;
    repeat (8) tick();
    check("mrst_pre_q", q_clean, 1'b0);
    sig_in = 1'b1;
    repeat (3) tick();
    check("mrst_busy_e3", busy, 1'b1);
    rst = 1'b0;
    tick();
    check("mrst_q_e4", q_clean, 1'b0);
    check("mrst_busy_e4", busy, 1'b0);
    check("mrst_rise_e4", rise, 1'b0);
    rst = 1'b1;
    repeat (5) tick();
    check("mrst_after_q_e5", q_clean, 1'b0);
    tick();
    check("mrst_after_q_e6", q_clean, 1'b1);
    check("mrst_after_rise_e6", rise, 1'b1);

    // 6b: DEBOUNCE_CYCLES=1 gives a 3-edge latency
    rst1 = 1'b1;
    tick(); tick();
    check("db1_idle_q", q_clean1, 1'b0);
    sig_in1 = 1'b1;
    tick(); tick();
    check("db1_q_e2", q_clean1, 1'b0);
    tick();
    check("db1_q_e3", q_clean1, 1'b1);
    check("db1_rise_e3", rise1, 1'b1);
    check("db1_busy_e3", busy1, 1'b0);
    tick();
    check("db1_rise_e4", rise1, 1'b0);
    sig_in1 = 1'b0;
    tick(); tick();
    check("db1_fq_e2", q_clean1, 1'b1);
    tick();
    check("db1_fq_e3", q_clean1, 1'b0);
    check("db1_fall_e3", fall1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_din_debounce_sync
